// File: rtl/issue_queue.sv
// Dual-ported in-order issue buffer between ID1 decode and the ID2 issue registers.
// Takes up to two entries per cycle and offers up to two per cycle, splitting a RAW-hazarded pair.
module issue_queue #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned ENTRY_W = 191
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     exception_flush,
    input  logic                     stall,
    input  logic                     in0_valid,
    input  logic [ENTRY_W-1:0]       in0_entry,
    input  logic                     in1_valid,
    input  logic [ENTRY_W-1:0]       in1_entry,
    output logic                     in_ready,
    output logic                     out0_valid,
    output logic [ENTRY_W-1:0]       out0_entry,
    output logic                     out1_valid,
    output logic [ENTRY_W-1:0]       out1_entry,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    // Field offsets inside the packed entry
    localparam int unsigned RS_LSB  = 122;
    localparam int unsigned RT_LSB  = 127;
    localparam int unsigned WEN_BIT = 142;
    localparam int unsigned DST_LSB = 143;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];
    logic [PW-1:0]      head_q, head_d;
    logic [PW-1:0]      tail_q, tail_d;
    logic [CW-1:0]      count_q, count_d;

    logic [PW-1:0]      head_p1;
    logic [PW-1:0]      tail_p1;
    logic [ENTRY_W-1:0] e0;
    logic [ENTRY_W-1:0] e1;
    logic [4:0]         e0_dst;
    logic               hazard;
    logic               clear;
    logic [CW-1:0]      push_n;
    logic [CW-1:0]      pop_n;

    assign head_p1 = head_q + PW'(1);
    assign tail_p1 = tail_q + PW'(1);
    assign e0      = mem_q[head_q];
    assign e1      = mem_q[head_p1];
    assign e0_dst  = e0[DST_LSB +: 5];

    assign hazard = e0[WEN_BIT] && (e0_dst != 5'd0) &&
                    ((e1[RS_LSB +: 5] == e0_dst) || (e1[RT_LSB +: 5] == e0_dst));

    assign out0_valid = (count_q != '0);
    assign out1_valid = (count_q >= CW'(2)) && !hazard;
    assign out0_entry = out0_valid ? e0 : '0;
    assign out1_entry = out1_valid ? e1 : '0;
    assign in_ready   = (count_q <= CW'(DEPTH - 2));
    assign count      = count_q;

    assign clear = exception_flush || (flush && !stall);

    always_comb begin
        pop_n = '0;
        if (!stall) begin
            pop_n = CW'(out0_valid) + CW'(out1_valid);
        end
    end

    // in1 without in0 is a protocol error and writes nothing
    always_comb begin
        push_n = '0;
        if (in_ready && in0_valid) begin
            push_n = in1_valid ? CW'(2) : CW'(1);
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PW'(pop_n);
            tail_d  = tail_q + PW'(push_n);
            count_d = count_q + push_n - pop_n;
            if (push_n != '0) begin
                mem_d[tail_q] = in0_entry;
            end
            if (push_n == CW'(2)) begin
                mem_d[tail_p1] = in1_entry;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: every read is masked by the occupancy count
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_issue_queue.sv
// Scoreboard bench for issue_queue: the stimulus enqueues accepted entries in program order,
// a negedge monitor checks the offered pair against the queue head and retires what issues.
module tb_issue_queue;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned ENTRY_W = 191;

    typedef struct packed {
        logic        in_delay_slot;
        logic [25:0] j_imme;
        logic [15:0] imme;
        logic [4:0]  w_reg_dst;
        logic        w_reg_ena;
        logic [4:0]  sa;
        logic [4:0]  rd;
        logic [4:0]  rt;
        logic [4:0]  rs;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [28:0] func_codes;
        logic [28:0] op_codes;
    } entry_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               flush = 1'b0;
    logic               exception_flush = 1'b0;
    logic               stall = 1'b0;
    logic               in0_valid = 1'b0;
    logic               in1_valid = 1'b0;
    entry_t             in0_entry = '0;
    entry_t             in1_entry = '0;
    logic               in_ready;
    logic               out0_valid;
    logic               out1_valid;
    logic [ENTRY_W-1:0] out0_entry;
    logic [ENTRY_W-1:0] out1_entry;
    logic [3:0]         count;

    entry_t      exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    bit          done     = 1'b0;
    logic [31:0] pc_ctr   = 32'h100;

    always #5 clk = ~clk;

    issue_queue #(.DEPTH(DEPTH), .ENTRY_W(ENTRY_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .exception_flush(exception_flush), .stall(stall),
        .in0_valid(in0_valid), .in0_entry(in0_entry), .in1_valid(in1_valid), .in1_entry(in1_entry),
        .in_ready(in_ready), .out0_valid(out0_valid), .out0_entry(out0_entry),
        .out1_valid(out1_valid), .out1_entry(out1_entry), .count(count)
    );

    task automatic chk(input string nm, input logic [ENTRY_W-1:0] got, input logic [ENTRY_W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    function automatic bit raw_hazard(input entry_t older, input entry_t younger);
        return older.w_reg_ena && (older.w_reg_dst != 5'd0) &&
               ((younger.rs == older.w_reg_dst) || (younger.rt == older.w_reg_dst));
    endfunction

    function automatic entry_t mk(input logic [31:0] pc, input logic wen, input logic [4:0] dst,
                                  input logic [4:0] rs, input logic [4:0] rt);
        entry_t e;
        e.in_delay_slot = 1'($urandom);
        e.j_imme        = 26'($urandom);
        e.imme          = 16'($urandom);
        e.w_reg_dst     = dst;
        e.w_reg_ena     = wen;
        e.sa            = 5'($urandom);
        e.rd            = 5'($urandom);
        e.rt            = rt;
        e.rs            = rs;
        e.inst          = $urandom;
        e.pc            = pc;
        e.func_codes    = 29'($urandom);
        e.op_codes      = 29'($urandom);
        return e;
    endfunction

    function automatic entry_t rnd();
        entry_t e;
        e = mk(pc_ctr, 1'($urandom), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
        pc_ctr = pc_ctr + 32'd4;
        return e;
    endfunction

    // Drives one cycle of inputs (called just after a posedge), then records accepted entries
    task automatic step(input logic r, input logic ef, input logic fl, input logic st,
                        input logic v0, input logic v1, input entry_t e0, input entry_t e1);
        int unsigned sz;
        bit          acc;
        sz  = exp_q.size();
        acc = !(r || ef || (fl && !st)) && (sz + 2 <= DEPTH) && v0;
        rst = r; exception_flush = ef; flush = fl; stall = st;
        in0_valid = v0; in1_valid = v1; in0_entry = e0; in1_entry = e1;
        @(posedge clk);
        if (acc) begin
            exp_q.push_back(e0);
            if (v1) exp_q.push_back(e1);
        end
        #1;
    endtask

    task automatic idle(input logic st);
        step(1'b0, 1'b0, 1'b0, st, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic push_pair(input logic st);
        entry_t a, b;
        a = mk(pc_ctr, 1'b0, 5'd0, 5'd1, 5'd2);
        b = mk(pc_ctr + 32'd4, 1'b0, 5'd0, 5'd3, 5'd4);
        pc_ctr = pc_ctr + 32'd8;
        step(1'b0, 1'b0, 1'b0, st, 1'b1, 1'b1, a, b);
    endtask

    // Monitor: compares the offered view with the scoreboard, then retires issued entries
    initial begin
        int unsigned sz;
        bit          v1;
        entry_t      h0, h1;
        while (!done) begin
            @(negedge clk);
            if (!done) begin
                sz = exp_q.size();
                h0 = (sz >= 1) ? exp_q[0] : '0;
                h1 = (sz >= 2) ? exp_q[1] : '0;
                v1 = (sz >= 2) && !raw_hazard(h0, h1);
                chk("count", ENTRY_W'(count), ENTRY_W'(sz));
                chk("in_ready", ENTRY_W'(in_ready), ENTRY_W'(sz + 2 <= DEPTH));
                chk("out0_valid", ENTRY_W'(out0_valid), ENTRY_W'(sz >= 1));
                chk("out0_entry", out0_entry, h0);
                chk("out1_valid", ENTRY_W'(out1_valid), ENTRY_W'(v1));
                chk("out1_entry", out1_entry, v1 ? h1 : '0);
                if (rst || exception_flush || (flush && !stall)) begin
                    exp_q.delete();
                end else if (!stall) begin
                    if (sz >= 1) void'(exp_q.pop_front());
                    if (v1) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        entry_t a, b, o;
        // T1: reset, then a non-hazard pair dual-issues
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        chk("rst_count", ENTRY_W'(count), ENTRY_W'(0));
        chk("rst_in_ready", ENTRY_W'(in_ready), ENTRY_W'(1));
        chk("rst_out0_valid", ENTRY_W'(out0_valid), ENTRY_W'(0));
        a = mk(32'h100, 1'b0, 5'd0, 5'd1, 5'd2);
        b = mk(32'h104, 1'b0, 5'd0, 5'd3, 5'd4);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, a, b);
        o = entry_t'(out0_entry);
        chk("t1_pc0", ENTRY_W'(o.pc), ENTRY_W'(32'h100));
        o = entry_t'(out1_entry);
        chk("t1_pc1", ENTRY_W'(o.pc), ENTRY_W'(32'h104));
        chk("t1_count", ENTRY_W'(count), ENTRY_W'(2));
        idle(1'b0);
        chk("t1_drained", ENTRY_W'(count), ENTRY_W'(0));

        // T2: RAW hazard splits the pair; dst=0 never hazards
        a = mk(32'h200, 1'b1, 5'd5, 5'd1, 5'd2);
        b = mk(32'h204, 1'b0, 5'd0, 5'd5, 5'd6);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, a, b);
        chk("t2_out1_blocked", ENTRY_W'(out1_valid), ENTRY_W'(0));
        idle(1'b0);
        chk("t2_count", ENTRY_W'(count), ENTRY_W'(1));
        o = entry_t'(out0_entry);
        chk("t2_e1_at_head", ENTRY_W'(o.pc), ENTRY_W'(32'h204));
        idle(1'b0);
        a = mk(32'h300, 1'b1, 5'd0, 5'd1, 5'd2);
        b = mk(32'h304, 1'b0, 5'd0, 5'd0, 5'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, a, b);
        chk("t2_dst0_dual", ENTRY_W'(out1_valid), ENTRY_W'(1));
        idle(1'b0);

        // T3: fill under stall until full, extra pair ignored, then drain
        for (int i = 0; i < 4; i++) push_pair(1'b1);
        chk("t3_full", ENTRY_W'(count), ENTRY_W'(8));
        chk("t3_not_ready", ENTRY_W'(in_ready), ENTRY_W'(0));
        push_pair(1'b1);
        chk("t3_ignored", ENTRY_W'(count), ENTRY_W'(8));
        for (int i = 0; i < 4; i++) begin
            idle(1'b0);
            chk("t3_drain", ENTRY_W'(count), ENTRY_W'(6 - 2 * i));
        end

        // T4: random traffic with stall/flush
        for (int i = 0; i < 150; i++) begin
            logic st, v0, v1, fl, ef;
            st = ($urandom_range(0, 2) == 0);
            v0 = ($urandom_range(0, 3) != 0);
            v1 = ($urandom_range(0, 2) != 0);
            fl = ($urandom_range(0, 24) == 0);
            ef = ($urandom_range(0, 39) == 0);
            a = rnd();
            b = rnd();
            step(1'b0, ef, fl, st, v0, v1, a, b);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);

        // T5: flush interaction with stall
        push_pair(1'b1);
        push_pair(1'b1);
        chk("t5_fill", ENTRY_W'(count), ENTRY_W'(4));
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
        chk("t5_flush_stalled", ENTRY_W'(count), ENTRY_W'(4));
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        chk("t5_flush", ENTRY_W'(count), ENTRY_W'(0));
        push_pair(1'b1);
        push_pair(1'b1);
        a = rnd();
        b = rnd();
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, a, b);
        chk("t5_exc_flush", ENTRY_W'(count), ENTRY_W'(0));

        // T6: reset mid-operation while a pair is pushing
        push_pair(1'b1);
        push_pair(1'b1);
        a = rnd();
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, a, '0);
        chk("t6_fill", ENTRY_W'(count), ENTRY_W'(5));
        a = rnd();
        b = rnd();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, a, b);
        chk("t6_count", ENTRY_W'(count), ENTRY_W'(0));
        chk("t6_in_ready", ENTRY_W'(in_ready), ENTRY_W'(1));
        chk("t6_out0_entry", out0_entry, '0);
        idle(1'b0);
        idle(1'b0);

        done = 1'b1;
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
